// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - five-way round-robin output-port arbiter with hold quantum and ON/OFF stall
module round_robin_arbiter #(
  parameter int N_PORTS = 5,
  parameter int QUANTUM = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req,
  input  logic               ON_OFF_signal,
  output logic [N_PORTS-1:0] grant
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [PTR_W:0]   N_EXT    = (PTR_W+1)'(N_PORTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

  logic [PTR_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;

  logic [PTR_W-1:0]   g_idx;
  logic               has_grant;
  logic               hold;
  logic [PTR_W-1:0]   start;
  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   idx;

  logic [N_PORTS-1:0] grant_nxt;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  // Port index modulo N_PORTS; a and b are both below N_PORTS so one subtract suffices
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a,
                                                input logic [PTR_W:0]   b);
    logic [PTR_W:0] s;
    s = {1'b0, a} + b;
    if (s >= N_EXT) s = s - N_EXT;
    return s[PTR_W-1:0];
  endfunction

  // Decode the current holder, decide hold vs re-arbitrate, and scan for the next winner
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[i]) g_idx = PTR_W'(i);
    end
    has_grant = |grant;
    hold      = has_grant && req[g_idx] && (cnt < CNT_LAST);

    // After a grant the scan starts just past the holder, so the holder itself is tried last
    start = has_grant ? wrap_add(g_idx, (PTR_W+1)'(1)) : ptr;

    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = wrap_add(start, (PTR_W+1)'(k));
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    grant_nxt = '0;
    ptr_nxt   = ptr;
    cnt_nxt   = '0;
    if (hold) begin
      grant_nxt = grant;
      cnt_nxt   = cnt + CNT_W'(1);
    end else if (found) begin
      grant_nxt[win] = 1'b1;
      ptr_nxt        = wrap_add(win, (PTR_W+1)'(1));
    end else begin
      ptr_nxt = start;
    end
  end

  // State update; OFF freezes everything so stalled cycles do not consume the quantum
  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else if (!ON_OFF_signal) begin
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb/tb_round_robin_arbiter.sv - table, directed and randomized checks of round_robin_arbiter
module tb_round_robin_arbiter;

  localparam int NP = 5;
  localparam int Q  = 4;

  logic          clk;
  logic          rst;
  logic [NP-1:0] req;
  logic          ON_OFF_signal;
  logic [NP-1:0] grant;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          rst;
    logic [NP-1:0] req;
    logic          off;
    logic [NP-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Reference model: holder index (-1 = none), rotation pointer, cycles used by the holder
  int m_g;
  int m_ptr;
  int m_used;

  round_robin_arbiter #(.N_PORTS(NP), .QUANTUM(Q)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .ON_OFF_signal (ON_OFF_signal),
    .grant         (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic [NP-1:0] rq, input logic off,
                              input logic [NP-1:0] e, input int n);
    vec_t v;
    v.rst = r; v.req = rq; v.off = off; v.exp = e;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  task automatic model_step(input logic r, input logic [NP-1:0] rq, input logic off);
    int s;
    int w;
    if (r) begin
      m_g = -1; m_ptr = 0; m_used = 0;
    end else if (!off) begin
      if (m_g >= 0 && rq[m_g] && m_used < Q) begin
        m_used++;
      end else begin
        s = (m_g >= 0) ? (m_g + 1) % NP : m_ptr;
        w = -1;
        for (int k = 0; k < NP; k++)
          if (w < 0 && rq[(s + k) % NP]) w = (s + k) % NP;
        if (w >= 0) begin
          m_g = w; m_ptr = (w + 1) % NP; m_used = 1;
        end else begin
          m_g = -1; m_ptr = s; m_used = 0;
        end
      end
    end
  endtask

  function automatic logic [NP-1:0] model_grant();
    logic [NP-1:0] g;
    g = '0;
    if (m_g >= 0) g[m_g] = 1'b1;
    return g;
  endfunction

  task automatic check(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: grant=%b expected=%b", name, act, exp);
    end
  endtask

  // Apply inputs just after an edge, take the next edge, then sample 1 time unit later
  task automatic tick(input logic r, input logic [NP-1:0] rq, input logic off);
    rst = r; req = rq; ON_OFF_signal = off;
    @(posedge clk);
    model_step(r, rq, off);
    #1;
  endtask

  initial begin
    logic [NP-1:0] rq;
    logic          r;
    logic          off;

    rst = 1'b1; req = '0; ON_OFF_signal = 1'b0;
    m_g = -1; m_ptr = 0; m_used = 0;

    // Reset, then two requesters alternate every quantum
    add(1, 5'b00000, 0, 5'b00000, 2);
    add(0, 5'b00000, 0, 5'b00000, 1);
    add(0, 5'b00011, 0, 5'b00001, 4);
    add(0, 5'b00011, 0, 5'b00010, 4);
    add(0, 5'b00011, 0, 5'b00001, 4);
    // All five requesting: full rotation
    add(1, 5'b11111, 0, 5'b00000, 1);
    add(0, 5'b11111, 0, 5'b00001, 4);
    add(0, 5'b11111, 0, 5'b00010, 4);
    add(0, 5'b11111, 0, 5'b00100, 4);
    add(0, 5'b11111, 0, 5'b01000, 4);
    add(0, 5'b11111, 0, 5'b10000, 4);
    add(0, 5'b11111, 0, 5'b00001, 4);
    // Stall right after grant stretches the hold to 7 cycles
    add(1, 5'b00000, 0, 5'b00000, 1);
    add(0, 5'b00011, 0, 5'b00001, 1);
    add(0, 5'b00011, 1, 5'b00001, 3);
    add(0, 5'b00011, 0, 5'b00001, 3);
    add(0, 5'b00011, 0, 5'b00010, 1);
    // Holder drops request after 2 cycles
    add(1, 5'b00000, 0, 5'b00000, 1);
    add(0, 5'b00101, 0, 5'b00001, 2);
    add(0, 5'b00100, 0, 5'b00100, 4);
    // Lone requester is regranted with no bubble, then releases
    add(1, 5'b00000, 0, 5'b00000, 1);
    add(0, 5'b01000, 0, 5'b01000, 10);
    add(0, 5'b00000, 0, 5'b00000, 2);
    // Reset while port 2 holds, then restart from port 0
    add(1, 5'b00000, 0, 5'b00000, 1);
    add(0, 5'b11111, 0, 5'b00001, 4);
    add(0, 5'b11111, 0, 5'b00010, 4);
    add(0, 5'b11111, 0, 5'b00100, 1);
    add(1, 5'b11111, 0, 5'b00000, 1);
    add(0, 5'b11111, 0, 5'b00001, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].rst, tbl[i].req, tbl[i].off);
      check($sformatf("vec%0d", i), grant, tbl[i].exp);
    end

    // Reset wins over a simultaneous OFF; OFF then holds the cleared state
    tick(1, 5'b00000, 0);
    tick(0, 5'b11111, 0); check("rst_off_pre",   grant, 5'b00001);
    tick(1, 5'b11111, 1); check("rst_off_clear", grant, 5'b00000);
    tick(0, 5'b11111, 1); check("rst_off_stall", grant, 5'b00000);
    tick(0, 5'b11111, 0); check("rst_off_resume", grant, 5'b00001);

    // A request arriving mid-hold waits for the quantum to expire
    tick(1, 5'b00000, 0);
    tick(0, 5'b00010, 0); check("late_first", grant, 5'b00010);
    for (int i = 0; i < 3; i++) begin
      tick(0, 5'b00011, 0); check($sformatf("late_hold%0d", i), grant, 5'b00010);
    end
    tick(0, 5'b00011, 0); check("late_switch", grant, 5'b00001);

    // Randomized traffic against the reference model
    tick(1, 5'b00000, 0);
    rq = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3) rq = NP'($urandom_range(0, 31));
      off = ($urandom_range(0, 4) == 0);
      r   = ($urandom_range(0, 59) == 0);
      tick(r, rq, off);
      check($sformatf("rand%0d", i), grant, model_grant());
      n_checks++;
      if ($countones(grant) > 1) begin
        n_fail++;
        $display("FAIL onehot%0d: grant=%b expected at most one bit set", i, grant);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
